// File: rtl/modport_fifo_if.sv
// Bus interface for modport_fifo: write/read handshake, read data and status flags.
// Optional error flags (overflow/underflow) exist only when FIFO_ERR_FLAGS_EN is defined.
// Handshake: a write is taken on a rising clk edge when wr_enb=1 and the FIFO is not full
// (or is full and a read is taken in the same edge); a read is taken when rd_enb=1 and the
// FIFO is not empty, with rd_data valid from the following cycle until the next read.
interface modport_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wr_enb;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_enb;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  half;
`ifdef FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_enb, wr_data, rd_enb,
        input  rd_data, full, empty, almost_full, almost_empty, half, overflow, underflow
    );

    modport slave (
        input  wr_enb, wr_data, rd_enb,
        output rd_data, full, empty, almost_full, almost_empty, half, overflow, underflow
    );
`else
    modport master (
        output wr_enb, wr_data, rd_enb,
        input  rd_data, full, empty, almost_full, almost_empty, half
    );

    modport slave (
        input  wr_enb, wr_data, rd_enb,
        output rd_data, full, empty, almost_full, almost_empty, half
    );
`endif
endinterface

// File: rtl/modport_fifo.sv
// Synchronous FIFO with registered read data and occupancy-decoded flags.
// Optional feature macro: FIFO_ERR_FLAGS_EN adds one-cycle overflow/underflow pulses.
// DEPTH must be a power of two and at least 4; pointers wrap naturally modulo DEPTH.
module modport_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_TH      = DEPTH - 2,
    parameter int AE_TH      = 2
) (
    input  logic           clk,
    input  logic           rst,
    modport_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] HALF_C = CW'(DEPTH / 2);
    localparam logic [CW-1:0] AF_C   = CW'(AF_TH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_TH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  do_write;
    logic                  do_read;

    // Flags are pure decodes of the registered count so they move with it.
    assign bus.full         = (count == FULL_C);
    assign bus.empty        = (count == '0);
    assign bus.almost_full  = (count >= AF_C);
    assign bus.almost_empty = (count <= AE_C);
    assign bus.half         = (count >= HALF_C);
    assign bus.rd_data      = rd_data_q;

    // Accept decisions; a full FIFO still takes a write when a read frees a slot the same edge,
    // while an empty FIFO never reads through the incoming word.
    always_comb begin
        do_read    = bus.rd_enb && !bus.empty;
        do_write   = bus.wr_enb && (!bus.full || do_read);
        count_next = count;
        case ({do_write, do_read})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Storage array; contents are not reset, stale entries are unreachable after reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers, occupancy and registered read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data_q <= '0;
        end else begin
            count <= count_next;
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_read) begin
                rd_data_q <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + AW'(1);
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    // One-cycle pulses flagging a dropped write or a dropped read on the previous edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= bus.wr_enb && !do_write;
            underflow_q <= bus.rd_enb && !do_read;
        end
    end
`endif

endmodule

// File: tb/tb_modport_fifo.sv
// Directed testbench for modport_fifo (DATA_WIDTH=8, DEPTH=16, default thresholds).
// Covers reset, fill/overflow, drain/underflow, mid-operation reset, concurrent access
// at 5 entries across pointer wrap, concurrent access when full and when empty.
module tb_modport_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_word;

    modport_fifo_if #(.DATA_WIDTH(DW)) bus ();

    modport_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
        bus.wr_enb  = w;
        bus.wr_data = d;
        bus.rd_enb  = r;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected flag values for a given occupancy with DEPTH=16, AF_TH=14, AE_TH=2.
    task automatic check_flags(input string tag, input int occ);
        check({tag, ".count"}, 32'(dut.count), 32'(occ));
        check({tag, ".full"}, 32'(bus.full), 32'(occ == 16));
        check({tag, ".empty"}, 32'(bus.empty), 32'(occ == 0));
        check({tag, ".almost_full"}, 32'(bus.almost_full), 32'(occ >= 14));
        check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(occ <= 2));
        check({tag, ".half"}, 32'(bus.half), 32'(occ >= 8));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(1'b0, '0, 1'b0);

        // Reset state
        #3;
        check_flags("reset", 0);
        check("reset.rd_data", 32'(bus.rd_data), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, DW'(i), 1'b0);
            tick();
            check_flags($sformatf("fill%0d", i + 1), i + 1);
        end

        // 17th write while full is dropped
        drive(1'b1, 8'hAA, 1'b0);
        tick();
        check_flags("overflow_write", 16);
        check("overflow_write.wr_ptr", 32'(dut.wr_ptr), 32'h0);
`ifdef FIFO_ERR_FLAGS_EN
        check("overflow_pulse", 32'(bus.overflow), 32'h1);
`endif
        drive(1'b0, '0, 1'b0);
        tick();
`ifdef FIFO_ERR_FLAGS_EN
        check("overflow_clear", 32'(bus.overflow), 32'h0);
`endif

        // Drain: data returns 0x00..0x0F, never the dropped 0xAA
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, '0, 1'b1);
            tick();
            check($sformatf("drain%0d.rd_data", i + 1), 32'(bus.rd_data), 32'(i));
            check_flags($sformatf("drain%0d", i + 1), 15 - i);
        end

        // 17th read while empty leaves rd_data alone
        drive(1'b0, '0, 1'b1);
        tick();
        check("underflow_read.rd_data", 32'(bus.rd_data), 32'h0F);
        check_flags("underflow_read", 0);
`ifdef FIFO_ERR_FLAGS_EN
        check("underflow_pulse", 32'(bus.underflow), 32'h1);
`endif
        drive(1'b0, '0, 1'b0);
        tick();
`ifdef FIFO_ERR_FLAGS_EN
        check("underflow_clear", 32'(bus.underflow), 32'h0);
`endif

        // Mid-operation reset: three entries stored, one read out, then async clear
        drive(1'b1, 8'h11, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b0); tick();
        drive(1'b1, 8'h33, 1'b0); tick();
        drive(1'b0, '0, 1'b1);    tick();
        check("pre_reset.rd_data", 32'(bus.rd_data), 32'h11);
        check_flags("pre_reset", 2);
        drive(1'b0, '0, 1'b0);
        #1 rst = 1'b0;
        #1;
        check_flags("async_reset", 0);
        check("async_reset.rd_data", 32'(bus.rd_data), 32'h0);
        check("async_reset.wr_ptr", 32'(dut.wr_ptr), 32'h0);
        check("async_reset.rd_ptr", 32'(dut.rd_ptr), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        // Stored entries are gone: a read right after reset does nothing
        drive(1'b0, '0, 1'b1);
        tick();
        check("post_reset_read.rd_data", 32'(bus.rd_data), 32'h0);
        check_flags("post_reset_read", 0);

        // Concurrent access at 5 entries for 40 cycles, pointers wrap
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, DW'(8'h50 + i), 1'b0);
            exp_q.push_back(DW'(8'h50 + i));
            tick();
        end
        check_flags("sim5_setup", 5);
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, DW'(8'h55 + k), 1'b1);
            exp_word = exp_q.pop_front();
            exp_q.push_back(DW'(8'h55 + k));
            tick();
            check($sformatf("sim5_%0d.rd_data", k), 32'(bus.rd_data), 32'(exp_word));
            check($sformatf("sim5_%0d.count", k), 32'(dut.count), 32'd5);
        end
        check("sim5.wr_ptr", 32'(dut.wr_ptr), 32'd13);
        check("sim5.rd_ptr", 32'(dut.rd_ptr), 32'd8);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, 1'b1);
            exp_word = exp_q.pop_front();
            tick();
            check($sformatf("sim5_drain%0d.rd_data", i), 32'(bus.rd_data), 32'(exp_word));
        end
        check_flags("sim5_drained", 0);

        // Concurrent access when full
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, DW'(8'h80 + i), 1'b0);
            exp_q.push_back(DW'(8'h80 + i));
            tick();
        end
        check_flags("full_setup", 16);
        drive(1'b1, 8'hC0, 1'b1);
        exp_word = exp_q.pop_front();
        exp_q.push_back(8'hC0);
        tick();
        check("full_rw.rd_data", 32'(bus.rd_data), 32'h80);
        check("full_rw.expected_oldest", 32'(exp_word), 32'h80);
        check_flags("full_rw", 16);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, '0, 1'b1);
            exp_word = exp_q.pop_front();
            tick();
            check($sformatf("full_drain%0d.rd_data", i), 32'(bus.rd_data), 32'(exp_word));
        end
        check("full_drain_last", 32'(bus.rd_data), 32'hC0);
        check_flags("full_drained", 0);

        // Concurrent access when empty: write only, no read-through
        drive(1'b1, 8'hD1, 1'b1);
        tick();
        check("empty_rw.rd_data", 32'(bus.rd_data), 32'hC0);
        check_flags("empty_rw", 1);
`ifdef FIFO_ERR_FLAGS_EN
        check("empty_rw.underflow", 32'(bus.underflow), 32'h1);
`endif
        drive(1'b0, '0, 1'b1);
        tick();
        check("empty_rw_read.rd_data", 32'(bus.rd_data), 32'hD1);
        check_flags("empty_rw_read", 0);
        drive(1'b0, '0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
